// File: rtl/indication_input_demux_if.sv
// Bundle of the inbound pipe and the per-method indication signals.
// The master side drives messages in and the sink readies; the slave side
// is the demux block itself.
interface indication_input_demux_if #(
  parameter int DATA_W   = 32,
  parameter int WORDS    = 2,
  parameter int TAG_W    = 32,
  parameter int NUM_METH = 4
);
  localparam int PAY_W = DATA_W * WORDS;

  logic                    pipe_enq_ENA;
  logic [PAY_W+TAG_W-1:0]  pipe_enq_v;
  logic                    pipe_enq_RDY;
  logic [NUM_METH-1:0]     ind_ENA;
  logic [PAY_W-1:0]        ind_v;
  logic [NUM_METH-1:0]     ind_RDY;

  modport master (
    output pipe_enq_ENA, pipe_enq_v, ind_RDY,
    input  pipe_enq_RDY, ind_ENA, ind_v
  );

  modport slave (
    input  pipe_enq_ENA, pipe_enq_v, ind_RDY,
    output pipe_enq_RDY, ind_ENA, ind_v
  );
endinterface

// File: rtl/indication_input_demux.sv
// Indication-side receive block: decodes the message tag to a method channel,
// buffers payload + channel in a small FIFO, and offers only the FIFO head to
// its channel (strict in-order delivery). Unknown tags are counted and dropped.
module indication_input_demux #(
  parameter int DATA_W   = 32,
  parameter int WORDS    = 2,
  parameter int TAG_W    = 32,
  parameter int NUM_METH = 4,
  parameter int DEPTH    = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  indication_input_demux_if.slave bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_count
);
  localparam int PAY_W = DATA_W * WORDS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CH_W  = (NUM_METH > 1) ? $clog2(NUM_METH) : 1;
  localparam logic [TAG_W-1:0] MAX_TAG   = TAG_W'(NUM_METH);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [15:0]      drop_reg, drop_next;

  logic [PAY_W-1:0] pay_mem  [DEPTH];
  logic [CH_W-1:0]  chan_mem [DEPTH];

  logic [TAG_W-1:0] tag;
  logic [PAY_W-1:0] payload;
  logic [CH_W-1:0]  tag_chan;
  logic [CH_W-1:0]  head_chan;
  logic             tag_hit;
  logic             enq_rdy;
  logic             accept;
  logic             store;
  logic             drop;
  logic             deliver;

  assign tag     = bus.pipe_enq_v[TAG_W-1:0];
  assign payload = bus.pipe_enq_v[TAG_W +: PAY_W];
  assign tag_hit = (tag != '0) && (tag <= MAX_TAG);
  // Tags 1..NUM_METH map to channels 0..NUM_METH-1; low bits suffice modulo 2^CH_W.
  assign tag_chan = tag[CH_W-1:0] - 1'b1;

  // Ready depends only on the occupancy register: no full-bypass.
  assign enq_rdy  = (count_reg != FULL_CNT);
  assign accept   = bus.pipe_enq_ENA && enq_rdy;
  assign store    = accept && tag_hit;
  assign drop     = accept && !tag_hit;

  assign head_chan = chan_mem[rptr_reg];
  assign bus.ind_v = pay_mem[rptr_reg];
  assign bus.pipe_enq_RDY = enq_rdy;

  // Only the head entry is offered, and only to its own channel when ready.
  generate
    for (genvar gi = 0; gi < NUM_METH; gi++) begin : g_ena
      assign bus.ind_ENA[gi] = (count_reg != '0) && (head_chan == CH_W'(gi)) && bus.ind_RDY[gi];
    end
  endgenerate

  assign deliver    = |bus.ind_ENA;
  assign count      = count_reg;
  assign drop_count = drop_reg;

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    drop_next  = drop_reg;
    if (store)   wptr_next = wptr_reg + 1'b1;
    if (deliver) rptr_next = rptr_reg + 1'b1;
    if (store && !deliver)      count_next = count_reg + 1'b1;
    else if (!store && deliver) count_next = count_reg - 1'b1;
    if (drop && (drop_reg != 16'hFFFF)) drop_next = drop_reg + 1'b1;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      drop_reg  <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      drop_reg  <= drop_next;
    end
  end

  // FIFO storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge CLK) begin
    if (nRST && store) begin
      pay_mem[wptr_reg]  <= payload;
      chan_mem[wptr_reg] <= tag_chan;
    end
  end
endmodule

// File: tb/tb_indication_input_demux.sv
// Directed bench for indication_input_demux: a vector table for the basic
// decode/ordering/drop behaviour plus hand sequences for full, head blocking,
// mid-stream reset and drop counter saturation.
module tb_indication_input_demux;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [2:0]  count;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  indication_input_demux_if #(.DATA_W(32), .WORDS(2), .TAG_W(32), .NUM_METH(4)) bus ();

  indication_input_demux #(
    .DATA_W(32), .WORDS(2), .TAG_W(32), .NUM_METH(4), .DEPTH(4)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus),
    .count(count),
    .drop_count(drop_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ena;
    logic [31:0] tag;
    logic [63:0] pay;
    logic [3:0]  rdy;
    logic        exp_rdy;
    logic [3:0]  exp_ena;
    logic        chk_v;
    logic [63:0] exp_v;
    logic [2:0]  exp_count;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic ena, input logic [31:0] tag, input logic [63:0] pay,
                              input logic [3:0] rdy, input logic er, input logic [3:0] ee,
                              input logic cv, input logic [63:0] ev, input logic [2:0] ec,
                              input logic [15:0] ed);
    vec_t v;
    v.ena = ena; v.tag = tag; v.pay = pay; v.rdy = rdy;
    v.exp_rdy = er; v.exp_ena = ee; v.chk_v = cv; v.exp_v = ev;
    v.exp_count = ec; v.exp_drop = ed;
    return v;
  endfunction

  function automatic logic [63:0] pay_of(input int i);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = 32'hA000_0000 + 32'(i);
    lo = 32'hB000_0000 + 32'(i);
    return {hi, lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ena, input logic [31:0] tag, input logic [63:0] pay,
                       input logic [3:0] rdy);
    bus.pipe_enq_ENA = ena;
    bus.pipe_enq_v   = {pay, tag};
    bus.ind_RDY      = rdy;
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge.
  task automatic expect_cycle(input string name, input logic er, input logic [3:0] ee,
                              input logic cv, input logic [63:0] ev, input logic [2:0] ec,
                              input logic [15:0] ed);
    @(negedge CLK);
    chk({name, ".rdy"},   64'(bus.pipe_enq_RDY), 64'(er));
    chk({name, ".ena"},   64'(bus.ind_ENA),      64'(ee));
    chk({name, ".count"}, 64'(count),            64'(ec));
    chk({name, ".drop"},  64'(drop_count),       64'(ed));
    if (cv) chk({name, ".v"}, bus.ind_v, ev);
    $display("%s: rdy=%b ena=%b v=%h count=%0d drop=%0d", name, bus.pipe_enq_RDY,
             bus.ind_ENA, bus.ind_v, count, drop_count);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 32'd1, {32'h2, 32'h5}, 4'hF, 1, 4'b0000, 0, 64'h0, 0, 0);
    vecs[1]  = mk(0, 32'd0, 64'h0,          4'hF, 1, 4'b0001, 1, {32'h2, 32'h5}, 1, 0);
    vecs[2]  = mk(1, 32'd3, pay_of(1),      4'hF, 1, 4'b0000, 0, 64'h0, 0, 0);
    vecs[3]  = mk(1, 32'd1, pay_of(2),      4'hF, 1, 4'b0100, 1, pay_of(1), 1, 0);
    vecs[4]  = mk(1, 32'd4, pay_of(3),      4'hF, 1, 4'b0001, 1, pay_of(2), 1, 0);
    vecs[5]  = mk(1, 32'd2, pay_of(4),      4'hF, 1, 4'b1000, 1, pay_of(3), 1, 0);
    vecs[6]  = mk(0, 32'd0, 64'h0,          4'hF, 1, 4'b0010, 1, pay_of(4), 1, 0);
    vecs[7]  = mk(0, 32'd0, 64'h0,          4'hF, 1, 4'b0000, 0, 64'h0, 0, 0);
    vecs[8]  = mk(1, 32'd0, pay_of(5),      4'hF, 1, 4'b0000, 0, 64'h0, 0, 0);
    vecs[9]  = mk(1, 32'd2, pay_of(6),      4'hF, 1, 4'b0000, 0, 64'h0, 0, 1);
    vecs[10] = mk(1, 32'd5, pay_of(7),      4'hF, 1, 4'b0010, 1, pay_of(6), 1, 1);
    vecs[11] = mk(1, 32'hFFFF_FFFF, pay_of(8), 4'hF, 1, 4'b0000, 0, 64'h0, 0, 2);
    vecs[12] = mk(0, 32'd0, 64'h0,          4'hF, 1, 4'b0000, 0, 64'h0, 0, 3);

    nRST = 1'b0;
    drive(0, 32'd0, 64'h0, 4'hF);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    expect_cycle("reset", 1, 4'b0000, 0, 64'h0, 0, 0);

    // Table: single message, back-to-back ordering, drops.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].ena, vecs[i].tag, vecs[i].pay, vecs[i].rdy);
      expect_cycle($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ena,
                   vecs[i].chk_v, vecs[i].exp_v, vecs[i].exp_count, vecs[i].exp_drop);
    end

    // Full: sinks stalled, fifth enqueue refused, then drain.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'd1, pay_of(20 + i), 4'h0);
      expect_cycle($sformatf("full_enq%0d", i), (i < 4), 4'b0000, 0, 64'h0, 3'(i), 3);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'd0, 64'h0, 4'hF);
      expect_cycle($sformatf("full_drain%0d", i), (i != 0), 4'b0001, 1, pay_of(20 + i),
                   3'(4 - i), 3);
    end
    drive(0, 32'd0, 64'h0, 4'hF);
    expect_cycle("full_empty", 1, 4'b0000, 0, 64'h0, 0, 3);

    // Head blocking: ch0 not ready holds back the ch1 entry behind it.
    drive(1, 32'd1, pay_of(30), 4'b1110);
    expect_cycle("blk_enq0", 1, 4'b0000, 0, 64'h0, 0, 3);
    drive(1, 32'd2, pay_of(31), 4'b1110);
    expect_cycle("blk_enq1", 1, 4'b0000, 1, pay_of(30), 1, 3);
    drive(0, 32'd0, 64'h0, 4'b1110);
    expect_cycle("blk_hold0", 1, 4'b0000, 1, pay_of(30), 2, 3);
    expect_cycle("blk_hold1", 1, 4'b0000, 1, pay_of(30), 2, 3);
    drive(0, 32'd0, 64'h0, 4'hF);
    expect_cycle("blk_ch0", 1, 4'b0001, 1, pay_of(30), 2, 3);
    expect_cycle("blk_ch1", 1, 4'b0010, 1, pay_of(31), 1, 3);
    expect_cycle("blk_done", 1, 4'b0000, 0, 64'h0, 0, 3);

    // Mid-stream reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(i + 1), pay_of(40 + i), 4'h0);
      expect_cycle($sformatf("rst_enq%0d", i), 1, 4'b0000, 0, 64'h0, 3'(i), 3);
    end
    drive(0, 32'd0, 64'h0, 4'h0);
    expect_cycle("rst_queued", 1, 4'b0000, 0, 64'h0, 3, 3);
    nRST = 1'b0;
    drive(1, 32'd1, pay_of(49), 4'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    drive(0, 32'd0, 64'h0, 4'hF);
    expect_cycle("rst_after0", 1, 4'b0000, 0, 64'h0, 0, 0);
    expect_cycle("rst_after1", 1, 4'b0000, 0, 64'h0, 0, 0);
    expect_cycle("rst_after2", 1, 4'b0000, 0, 64'h0, 0, 0);
    drive(1, 32'd4, pay_of(50), 4'hF);
    expect_cycle("rst_new_enq", 1, 4'b0000, 0, 64'h0, 0, 0);
    drive(0, 32'd0, 64'h0, 4'hF);
    expect_cycle("rst_new_dlv", 1, 4'b1000, 1, pay_of(50), 1, 0);
    expect_cycle("rst_new_done", 1, 4'b0000, 0, 64'h0, 0, 0);

    // Drop counter saturation.
    drive(1, 32'd0, 64'h0, 4'hF);
    for (int i = 0; i < 65535; i++) begin
      @(posedge CLK);
    end
    #1;
    expect_cycle("sat0", 1, 4'b0000, 0, 64'h0, 0, 16'hFFFF);
    expect_cycle("sat1", 1, 4'b0000, 0, 64'h0, 0, 16'hFFFF);
    drive(1, 32'd9, 64'h0, 4'hF);
    expect_cycle("sat2", 1, 4'b0000, 0, 64'h0, 0, 16'hFFFF);
    drive(0, 32'd0, 64'h0, 4'hF);
    expect_cycle("sat3", 1, 4'b0000, 0, 64'h0, 0, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
